// File: rtl/matrix_commit_arbiter.sv
// matrix_commit_arbiter: round-robin grant of two matrix writers into one
// shadow buffer, committed to the renderer registers at vblank start.
module matrix_commit_arbiter #(
  parameter int          V_ACTIVE = 480,
  parameter int          MW       = 336,
  parameter logic [20:0] ONE_Q    = 21'h00400
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic [9:0]    v_cnt,
  input  logic          req0,
  input  logic [MW-1:0] mtrx0,
  input  logic [3:0]    state0,
  output logic          ack0,
  input  logic          req1,
  input  logic [MW-1:0] mtrx1,
  input  logic [3:0]    state1,
  output logic          ack1,
  output logic [MW-1:0] mtrxOut,
  output logic [3:0]    matrixState,
  output logic          pending,
  output logic          frame_commit,
  output logic [7:0]    frame_cnt
);

  localparam int          EW  = 21;
  localparam logic [9:0]  VBL = 10'(V_ACTIVE);
  localparam logic [EW-1:0] Z = '0;

  // Column-major packing {d11,d21,d31,d41,d12,...,d44}; MW is 16*EW.
  localparam logic [MW-1:0] IDENT = {
    ONE_Q, Z, Z, Z,
    Z, ONE_Q, Z, Z,
    Z, Z, ONE_Q, Z,
    Z, Z, Z, ONE_Q
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT_VBL,
    COMMIT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [9:0]    v_prev;
  logic          vblank_start;
  logic          grant;
  logic          winner;
  logic          commit;
  logic          last_grant;
  logic [MW-1:0] shadow_m;
  logic [3:0]    shadow_s;

  assign vblank_start = (v_cnt == VBL) && (v_prev != VBL);
  assign commit       = (state == COMMIT);

  // FSM state register.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and grant decision; ties go to the requester not last served.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    winner    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant     = 1'b1;
          winner    = (req0 && req1) ? ~last_grant : req1;
          state_nxt = WAIT_VBL;
        end
      end
      WAIT_VBL: begin
        if (vblank_start) state_nxt = COMMIT;
      end
      COMMIT: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vertical edge detection and frame counting, independent of the FSM.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      v_prev    <= '0;
      frame_cnt <= '0;
    end else begin
      v_prev <= v_cnt;
      if (vblank_start) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Shadow capture on grant, with one-cycle acknowledge pulses.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      shadow_m   <= '0;
      shadow_s   <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      ack0 <= grant && !winner;
      ack1 <= grant && winner;
      if (grant) begin
        shadow_m   <= winner ? mtrx1 : mtrx0;
        shadow_s   <= winner ? state1 : state0;
        last_grant <= winner;
      end
    end
  end

  // Renderer-facing registers move only when the FSM is in COMMIT.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mtrxOut      <= IDENT;
      matrixState  <= '0;
      pending      <= 1'b0;
      frame_commit <= 1'b0;
    end else begin
      frame_commit <= commit;
      if (grant) pending <= 1'b1;
      if (commit) begin
        mtrxOut     <= shadow_m;
        matrixState <= shadow_s;
        pending     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_commit_arbiter.sv
// tb_matrix_commit_arbiter: directed scenarios plus a randomized run
// compared cycle by cycle against an event-level reference model.
module tb_matrix_commit_arbiter;

  localparam int MW = 336;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic [9:0]    v_cnt = '0;
  logic          req0 = 1'b0;
  logic [MW-1:0] mtrx0 = '0;
  logic [3:0]    state0 = '0;
  logic          ack0;
  logic          req1 = 1'b0;
  logic [MW-1:0] mtrx1 = '0;
  logic [3:0]    state1 = '0;
  logic          ack1;
  logic [MW-1:0] mtrxOut;
  logic [3:0]    matrixState;
  logic          pending;
  logic          frame_commit;
  logic [7:0]    frame_cnt;

  int checks = 0;
  int errors = 0;

  matrix_commit_arbiter dut (
    .CLK(CLK), .rst(rst), .v_cnt(v_cnt),
    .req0(req0), .mtrx0(mtrx0), .state0(state0), .ack0(ack0),
    .req1(req1), .mtrx1(mtrx1), .state1(state1), .ack1(ack1),
    .mtrxOut(mtrxOut), .matrixState(matrixState), .pending(pending),
    .frame_commit(frame_commit), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  // Reference model: an update is either absent, waiting for a vblank,
  // or due to land on the next edge.
  logic [MW-1:0] m_out;
  logic [3:0]    m_st;
  logic [MW-1:0] m_sh;
  logic [3:0]    m_shs;
  logic [9:0]    m_vprev;
  bit            m_pend, m_land, m_last;
  bit            m_ack0, m_ack1, m_fc;
  int            m_frames;

  function automatic logic [MW-1:0] ident();
    logic [MW-1:0] r;
    int idx;
    r = '0;
    for (int c = 1; c <= 4; c++)
      for (int rw = 1; rw <= 4; rw++) begin
        idx = (c - 1) * 4 + (rw - 1);
        if (rw == c) r[MW-1-21*idx -: 21] = 21'h00400;
      end
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mtrx();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < 11; i++) r = {r[MW-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic model_reset();
    m_out = ident(); m_st = '0; m_sh = '0; m_shs = '0;
    m_vprev = '0; m_pend = 0; m_land = 0; m_last = 1;
    m_ack0 = 0; m_ack1 = 0; m_fc = 0; m_frames = 0;
  endtask

  task automatic model_edge();
    bit vb;
    bit w;
    vb = (v_cnt == 10'd480) && (m_vprev != 10'd480);
    m_vprev = v_cnt;
    if (vb) m_frames = (m_frames + 1) % 256;
    m_ack0 = 0; m_ack1 = 0; m_fc = 0;
    if (m_land) begin
      m_out = m_sh; m_st = m_shs; m_fc = 1;
      m_pend = 0; m_land = 0;
    end else if (m_pend) begin
      if (vb) m_land = 1;
    end else if (req0 || req1) begin
      if (req0 && req1) w = !m_last;
      else              w = req1;
      m_sh  = w ? mtrx1 : mtrx0;
      m_shs = w ? state1 : state0;
      m_last = w;
      m_ack0 = !w; m_ack1 = w;
      m_pend = 1;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (rst) model_reset();
    else     model_edge();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    req0 = 0; req1 = 0; v_cnt = '0;
    rst = 1;
    model_reset();
    repeat (2) @(negedge CLK);
    rst = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    tick();
    checks++;
    if (mtrxOut !== ident()) begin
      errors++; $display("FAIL reset_mtrx got %h exp %h", mtrxOut, ident());
    end
    checks++;
    if ({matrixState, pending, frame_commit, ack0, ack1} !== 8'h0) begin
      errors++;
      $display("FAIL reset_ctrl got st=%h p=%b fc=%b a0=%b a1=%b exp 0",
               matrixState, pending, frame_commit, ack0, ack1);
    end
    checks++;
    if (frame_cnt !== 8'd0) begin
      errors++; $display("FAIL reset_fcnt got %0d exp 0", frame_cnt);
    end
  endtask

  task automatic test_single();
    logic [MW-1:0] a;
    a = rand_mtrx();
    apply_reset();
    v_cnt = 10'd100; req0 = 1; mtrx0 = a; state0 = 4'h3;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0 || pending !== 1'b1) begin
      errors++; $display("FAIL single_ack got a0=%b a1=%b p=%b exp 1 0 1",
                         ack0, ack1, pending);
    end
    req0 = 0; mtrx0 = rand_mtrx(); state0 = 4'h9;
    tick();
    checks++;
    if (ack0 !== 1'b0) begin
      errors++; $display("FAIL single_ack_pulse got %b exp 0", ack0);
    end
    v_cnt = 10'd479;
    tick();
    v_cnt = 10'd480;
    tick();
    checks++;
    if (mtrxOut !== ident() || frame_commit !== 1'b0) begin
      errors++; $display("FAIL single_early got fc=%b mtrx=%h", frame_commit, mtrxOut);
    end
    tick();
    checks++;
    if (mtrxOut !== a || matrixState !== 4'h3) begin
      errors++; $display("FAIL single_commit got %h st=%h exp %h st=3",
                         mtrxOut, matrixState, a);
    end
    checks++;
    if (frame_commit !== 1'b1 || pending !== 1'b0) begin
      errors++; $display("FAIL single_flags got fc=%b p=%b exp 1 0",
                         frame_commit, pending);
    end
    tick();
    checks++;
    if (frame_commit !== 1'b0 || mtrxOut !== a) begin
      errors++; $display("FAIL single_after got fc=%b exp 0", frame_commit);
    end
  endtask

  task automatic test_round_robin();
    logic [MW-1:0] a0, a1;
    a0 = rand_mtrx(); a1 = rand_mtrx();
    apply_reset();
    v_cnt = 10'd100;
    req0 = 1; mtrx0 = a0; state0 = 4'h1;
    req1 = 1; mtrx1 = a1; state1 = 4'h2;
    tick();
    checks++;
    if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
      errors++; $display("FAIL rr_first got a0=%b a1=%b exp 1 0", ack0, ack1);
    end
    mtrx0 = rand_mtrx(); state0 = 4'h5;
    repeat (3) begin
      tick();
      checks++;
      if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
        errors++; $display("FAIL rr_stall got a0=%b a1=%b exp 0 0", ack0, ack1);
      end
    end
    v_cnt = 10'd480;
    tick();
    tick();
    checks++;
    if (frame_commit !== 1'b1 || mtrxOut !== a0 || ack1 !== 1'b0) begin
      errors++; $display("FAIL rr_commit0 got fc=%b a1=%b mtrx=%h",
                         frame_commit, ack1, mtrxOut);
    end
    tick();
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      errors++; $display("FAIL rr_second got a0=%b a1=%b exp 0 1", ack0, ack1);
    end
    req1 = 0;
    tick();
    checks++;
    if (frame_commit !== 1'b0 || mtrxOut !== a0) begin
      errors++; $display("FAIL rr_one_per_frame got fc=%b", frame_commit);
    end
    v_cnt = 10'd0;
    tick();
    v_cnt = 10'd480;
    tick();
    tick();
    checks++;
    if (frame_commit !== 1'b1 || mtrxOut !== a1 || matrixState !== 4'h2
        || frame_cnt !== 8'd2) begin
      errors++; $display("FAIL rr_commit1 got fc=%b st=%h fcnt=%0d mtrx=%h",
                         frame_commit, matrixState, frame_cnt, mtrxOut);
    end
    tick();
    checks++;
    if (ack0 !== 1'b1) begin
      errors++; $display("FAIL rr_third got a0=%b exp 1", ack0);
    end
    req0 = 0;
  endtask

  task automatic test_same_cycle();
    logic [MW-1:0] a;
    logic [7:0] base;
    a = rand_mtrx();
    apply_reset();
    v_cnt = 10'd479;
    tick();
    base = frame_cnt;
    v_cnt = 10'd480; req0 = 1; mtrx0 = a; state0 = 4'h7;
    tick();
    checks++;
    if (ack0 !== 1'b1 || frame_cnt !== base + 8'd1) begin
      errors++; $display("FAIL same_capture got a0=%b fcnt=%0d", ack0, frame_cnt);
    end
    req0 = 0;
    repeat (4) begin
      tick();
      checks++;
      if (frame_commit !== 1'b0 || mtrxOut !== ident()) begin
        errors++; $display("FAIL same_no_commit got fc=%b", frame_commit);
      end
    end
    v_cnt = 10'd0;
    tick();
    v_cnt = 10'd480;
    tick();
    tick();
    checks++;
    if (frame_commit !== 1'b1 || mtrxOut !== a || frame_cnt !== base + 8'd2) begin
      errors++; $display("FAIL same_next got fc=%b fcnt=%0d exp fcnt=%0d",
                         frame_commit, frame_cnt, base + 8'd2);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    v_cnt = 10'd480;
    repeat (20) tick();
    checks++;
    if (frame_cnt !== 8'd1) begin
      errors++; $display("FAIL wrap_hold got %0d exp 1", frame_cnt);
    end
    for (int i = 0; i < 259; i++) begin
      v_cnt = 10'd0;
      tick();
      v_cnt = 10'd480;
      tick();
    end
    checks++;
    if (frame_cnt !== 8'd4) begin
      errors++; $display("FAIL wrap_cnt got %0d exp 4", frame_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] b, c;
    b = rand_mtrx(); c = rand_mtrx();
    apply_reset();
    v_cnt = 10'd100; req0 = 1; mtrx0 = b; state0 = 4'hb;
    tick();
    req0 = 0;
    tick();
    checks++;
    if (pending !== 1'b1) begin
      errors++; $display("FAIL mid_pending got %b exp 1", pending);
    end
    #2 rst = 1;
    #1;
    checks++;
    if (mtrxOut !== ident() || pending !== 1'b0 || matrixState !== 4'h0) begin
      errors++; $display("FAIL mid_async got p=%b st=%h mtrx=%h",
                         pending, matrixState, mtrxOut);
    end
    model_reset();
    tick();
    tick();
    rst = 0;
    v_cnt = 10'd479;
    tick();
    v_cnt = 10'd480;
    repeat (3) begin
      tick();
      checks++;
      if (frame_commit !== 1'b0 || mtrxOut !== ident()) begin
        errors++; $display("FAIL mid_no_commit got fc=%b", frame_commit);
      end
    end
    v_cnt = 10'd100; req1 = 1; mtrx1 = c; state1 = 4'h4;
    tick();
    checks++;
    if (ack1 !== 1'b1 || ack0 !== 1'b0) begin
      errors++; $display("FAIL mid_regrant got a0=%b a1=%b exp 0 1", ack0, ack1);
    end
    req1 = 0;
    tick();
  endtask

  task automatic test_random();
    int r;
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 9);
      if (r < 4)      v_cnt = 10'd480;
      else if (r < 6) v_cnt = 10'd479;
      else            v_cnt = 10'($urandom_range(0, 1023));
      if (req0 && m_ack0) req0 = 0;
      else if (req0 && $urandom_range(0, 49) == 0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; mtrx0 = rand_mtrx(); state0 = 4'($urandom());
      end
      if (req1 && m_ack1) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; mtrx1 = rand_mtrx(); state1 = 4'($urandom());
      end
      tick();
      checks++;
      if (mtrxOut !== m_out || matrixState !== m_st) begin
        errors++; $display("FAIL rnd_out cyc=%0d got %h/%h exp %h/%h",
                           cyc, mtrxOut, matrixState, m_out, m_st);
      end
      checks++;
      if ({ack0, ack1, pending, frame_commit} !== {m_ack0, m_ack1, m_pend, m_fc}) begin
        errors++; $display("FAIL rnd_ctrl cyc=%0d got %b%b%b%b exp %b%b%b%b", cyc,
                           ack0, ack1, pending, frame_commit,
                           m_ack0, m_ack1, m_pend, m_fc);
      end
      checks++;
      if (frame_cnt !== 8'(m_frames)) begin
        errors++; $display("FAIL rnd_fcnt cyc=%0d got %0d exp %0d",
                           cyc, frame_cnt, m_frames);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_commit_arbiter.md
Name: matrix_commit_arbiter

Overview:
- Shares the renderer's transform-matrix input (336-bit mtrxIn, 4-bit matrixState) between two requesters, e.g. a rotation engine and a host/UART loader.
- Grants one request at a time, round-robin, into a single shadow buffer.
- Commits the shadow to the renderer-facing registers only at the start of vertical blanking, so a frame never shows a half-updated matrix.

Parameters:
- V_ACTIVE, 480, first v_cnt value of vertical blanking; a commit is triggered when v_cnt becomes this value.
- MW, 336, matrix bus width: 16 entries of 21-bit signed Q1.10.10.
- ONE_Q, 21'h00400, value 1.0 in Q1.10.10, used for the reset identity matrix.

Ports:
- CLK  in  1  system clock; v_cnt is synchronous to CLK
- rst  in  1  asynchronous, active-high reset
- v_cnt  in  10  VGA vertical counter
- req0  in  1  requester 0 update request; held high until ack0
- mtrx0  in  MW  requester 0 matrix, packed {d11,d21,d31,d41,d12,...,d44}
- state0  in  4  requester 0 matrixState
- ack0  out  1  one-cycle pulse: requester 0 data captured
- req1  in  1  requester 1 update request
- mtrx1  in  MW  requester 1 matrix
- state1  in  4  requester 1 matrixState
- ack1  out  1  one-cycle pulse: requester 1 data captured
- mtrxOut  out  MW  committed matrix to the renderer
- matrixState  out  4  committed state to the renderer
- pending  out  1  shadow holds an uncommitted update
- frame_commit  out  1  one-cycle pulse: commit performed
- frame_cnt  out  8  count of vblank starts, wraps 255->0

Behaviour:
- Reset values:
  - mtrxOut = identity: d11, d22, d33, d44 = ONE_Q; all other entries 0.
  - matrixState = 0; ack0 = ack1 = 0; pending = 0; frame_commit = 0; frame_cnt = 0.
  - Shadow = 0; v_prev = 0; last_grant = 1, so requester 0 wins first; FSM in IDLE.
- vblank_start (combinational) = (v_cnt == V_ACTIVE) && (v_prev != V_ACTIVE).
  - v_prev <= v_cnt every cycle.
  - frame_cnt increments on every vblank_start in any state.
- FSM states: IDLE, WAIT_VBL, COMMIT.
- IDLE:
  - If req0 or req1, the winner is chosen as follows:
    - Only one requesting: that one wins.
    - Both requesting: the one not equal to last_grant wins.
  - At the clock edge, the winner's mtrx and state are captured into the shadow.
  - ackN <= 1 for exactly one cycle; last_grant <= winner; pending <= 1; next state WAIT_VBL.
  - Latency: req sampled in cycle N, ack high in cycle N+1.
- WAIT_VBL:
  - Requests are not granted and ack stays 0; requesters remain stalled with req high.
  - On vblank_start -> COMMIT.
- COMMIT (exactly one cycle):
  - mtrxOut <= shadow matrix; matrixState <= shadow state; frame_commit <= 1 (high in the cycle after COMMIT).
  - pending <= 0; next state IDLE.
- Requests seen in COMMIT are evaluated in the following IDLE cycle, so at most one commit happens per frame.
- Capture in the same cycle as vblank_start: the capture proceeds and that vblank is not used for the commit. The commit occurs at the next frame's vblank_start.
- vblank_start in IDLE with no request: only frame_cnt updates; outputs are unchanged.
- Requesters must hold req until ack. Dropping req before ack simply withdraws the request, with no side effect.
- Captured data is held unchanged in the shadow; later input changes are ignored.
- mtrxOut and matrixState change only in the cycle after COMMIT. They are otherwise stable, including during active video.
- Reset mid-operation:
  - The pending shadow is discarded and no ack or commit is emitted.
  - Outputs return to the identity matrix; the FSM returns to IDLE.
- No arithmetic is applied to the matrix; all paths are pure register transfer, bit-exact.

Test Plan:
- Reset release -> mtrxOut has 21'h00400 at d11, d22, d33, d44 and 0 elsewhere; matrixState=0; pending=0; frame_cnt=0.
- req0 with mtrx0=pattern A and state0=4'h3 while v_cnt=100 -> ack0 one cycle later and pending=1. mtrxOut is unchanged until v_cnt steps 479->480, then mtrxOut=A and matrixState=3, with frame_commit one pulse, pending=0.
- req0 and req1 asserted together, both held -> ack0 first, commit at frame k; ack1 in the IDLE cycle after that commit, commit at frame k+1. Two grants alternate, never two commits per frame.
- Capture in the same cycle v_cnt reaches 480 -> no commit in that frame; commit at the next 480 entry; frame_cnt advances by 2 between capture and frame_commit.
- v_cnt held at 480 for many cycles, then 260 frames run -> exactly one vblank_start per entry; frame_cnt wraps to 4 after 260 entries.
- rst pulsed while in WAIT_VBL with pattern B pending -> no frame_commit; mtrxOut returns to identity; a following req1 is granted normally with ack1 one cycle later.
